sockit_spi_arb: RTL and testbench

N-channel arbiter that multiplexes the command (scw) and write-data (sdw) streams of several requesters (XIP, REG+DMA, future ports) onto the single serializer path. It routes read data (sdr) back to the owning requester. Grants are locked per SPI transaction, so slave-select framing is never interleaved between requesters. It replaces the fixed 2-way mux/fork pair and its hard-wired select in the top level.

---
 rtl/sockit_spi_pkg.sv | 28 ++
 rtl/sockit_spi_arb_sel.sv | 38 +++
 rtl/sockit_spi_arb.sv | 139 +++++++++++++
 tb/tb_sockit_spi_arb.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sockit_spi_pkg.sv
// Shared types for the sockit SPI master: command bit layout and
// arbiter state/mode encodings.
package sockit_spi_pkg;

    localparam int unsigned SPI_CW  = 32;
    localparam int unsigned CMD_LST = SPI_CW - 1;
    localparam int unsigned CMD_RD  = SPI_CW - 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY  = 2'd1,
        ARB_DRAIN = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_RR  = 1'b0,
        ARB_FIX = 1'b1
    } arb_mode_t;

    function automatic int unsigned cmd_lst_bit(int unsigned cw);
        return cw - 1;
    endfunction

    function automatic int unsigned cmd_rd_bit(int unsigned cw);
        return cw - 2;
    endfunction

endpackage

// File: rtl/sockit_spi_arb_sel.sv
// Combinational winner select: round-robin after ptr_i, or fixed
// priority with channel 0 highest.
module sockit_spi_arb_sel
    import sockit_spi_pkg::*;
#(
    parameter int unsigned CN = 2,
    localparam int unsigned IW = (CN > 1) ? $clog2(CN) : 1
) (
    input  logic [CN-1:0] req_i,
    input  logic [IW-1:0] ptr_i,
    input  arb_mode_t     mode_i,
    output logic [CN-1:0] oh_o,
    output logic [IW-1:0] idx_o
);

    logic          found;
    int unsigned   c;
    logic [IW-1:0] ci;

    always_comb begin
        oh_o  = '0;
        idx_o = '0;
        found = 1'b0;
        c     = 0;
        ci    = '0;
        for (int unsigned k = 0; k < CN; k++) begin
            if (mode_i == ARB_FIX) c = k;
            else c = (32'(ptr_i) + k + 32'd1) % CN;
            ci = IW'(c);
            if (req_i[ci] && !found) begin
                found     = 1'b1;
                oh_o[ci]  = 1'b1;
                idx_o     = ci;
            end
        end
    end

endmodule

// File: rtl/sockit_spi_arb.sv
// N-channel arbiter for the serializer command/write/read streams;
// the grant is held for a whole SPI transaction.
module sockit_spi_arb
    import sockit_spi_pkg::*;
#(
    parameter int unsigned CN  = 2,
    parameter int unsigned CW  = 32,
    parameter int unsigned DW  = 8,
    parameter int unsigned PRI = 0,
    parameter int unsigned OCW = 4,
    localparam int unsigned IW = (CN > 1) ? $clog2(CN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CN-1:0]    sci_vld,
    input  logic [CN*CW-1:0] sci_dat,
    output logic [CN-1:0]    sci_rdy,
    input  logic [CN-1:0]    swi_vld,
    input  logic [CN*DW-1:0] swi_dat,
    output logic [CN-1:0]    swi_rdy,
    output logic [CN-1:0]    sro_vld,
    output logic [DW-1:0]    sro_dat,
    input  logic [CN-1:0]    sro_rdy,
    output logic             sco_vld,
    output logic [CW-1:0]    sco_dat,
    input  logic             sco_rdy,
    output logic             swo_vld,
    output logic [DW-1:0]    swo_dat,
    input  logic             swo_rdy,
    input  logic             sri_vld,
    input  logic [DW-1:0]    sri_dat,
    output logic             sri_rdy,
    output logic             gnt_vld,
    output logic [IW-1:0]    gnt_idx,
    output logic             err_sro
);

    localparam int unsigned LST = cmd_lst_bit(CW);
    localparam int unsigned RD  = cmd_rd_bit(CW);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] gnt_q, gnt_d, ptr_q, ptr_d;
    logic [OCW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;

    arb_mode_t     mode;
    logic [CN-1:0] win_oh;
    logic [IW-1:0] win_idx;
    logic [CW-1:0] cmd;
    logic          cmd_rd, cmd_lst, busy, cnt_nz, stall;
    logic          cmd_acc, rd_cmd, rd_acc;

    assign mode = (PRI != 0) ? ARB_FIX : ARB_RR;

    sockit_spi_arb_sel #(.CN(CN)) u_sel (
        .req_i  (sci_vld),
        .ptr_i  (ptr_q),
        .mode_i (mode),
        .oh_o   (win_oh),
        .idx_o  (win_idx)
    );

    always_comb begin
        cmd     = sci_dat[gnt_q*CW +: CW];
        cmd_rd  = cmd[RD];
        cmd_lst = cmd[LST];
        busy    = (state_q == ARB_BUSY);
        cnt_nz  = (cnt_q != '0);
        // A read command must not overflow the in-flight counter.
        stall   = cmd_rd && (cnt_q == '1);

        sco_vld = busy && sci_vld[gnt_q] && !stall;
        sco_dat = cmd;
        sci_rdy = '0;
        sci_rdy[gnt_q] = busy && sco_rdy && !stall;

        swo_vld = busy && swi_vld[gnt_q];
        swo_dat = swi_dat[gnt_q*DW +: DW];
        swi_rdy = '0;
        swi_rdy[gnt_q] = busy && swo_rdy;

        sro_dat = sri_dat;
        sro_vld = '0;
        sro_vld[gnt_q] = sri_vld && cnt_nz;
        // Unsolicited beats are swallowed and flagged.
        sri_rdy = cnt_nz ? sro_rdy[gnt_q] : 1'b1;

        cmd_acc = sco_vld && sco_rdy;
        rd_cmd  = cmd_acc && cmd_rd;
        rd_acc  = sri_vld && sri_rdy && cnt_nz;
        err_d   = sri_vld && !cnt_nz;

        cnt_d = cnt_q;
        if (rd_cmd && !rd_acc) cnt_d = cnt_q + OCW'(1);
        else if (rd_acc && !rd_cmd) cnt_d = cnt_q - OCW'(1);

        state_d = state_q;
        gnt_d   = gnt_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (|win_oh) begin
                    state_d = ARB_BUSY;
                    gnt_d   = win_idx;
                    ptr_d   = win_idx;
                end
            end
            ARB_BUSY: begin
                if (cmd_acc && cmd_lst)
                    state_d = (cnt_d == '0) ? ARB_IDLE : ARB_DRAIN;
            end
            ARB_DRAIN: begin
                if (!cnt_nz) state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ARB_IDLE;
            gnt_q   <= '0;
            ptr_q   <= IW'(CN - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign gnt_vld = (state_q != ARB_IDLE);
    assign gnt_idx = gnt_q;
    assign err_sro = err_q;

endmodule

// File: tb/tb_sockit_spi_arb.sv
// Scoreboard bench: A = 2ch round-robin, B = 3ch fixed priority with
// a 2-bit outstanding-read counter.
module tb_sockit_spi_arb;
    import sockit_spi_pkg::*;

    localparam logic [31:0] L  = 32'h8000_0000;
    localparam logic [31:0] RD = 32'h4000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst, b_rst;

    logic [1:0]  a_sci_vld, a_sci_rdy, a_swi_vld, a_swi_rdy;
    logic [1:0]  a_sro_vld, a_sro_rdy;
    logic [63:0] a_sci_dat;
    logic [15:0] a_swi_dat;
    logic [7:0]  a_sro_dat, a_swo_dat, a_sri_dat;
    logic        a_sco_vld, a_sco_rdy, a_swo_vld, a_swo_rdy;
    logic        a_sri_vld, a_sri_rdy, a_gnt_vld, a_err;
    logic [31:0] a_sco_dat;
    logic [0:0]  a_gnt_idx;

    logic [2:0]  b_sci_vld, b_sci_rdy, b_swi_vld, b_swi_rdy;
    logic [2:0]  b_sro_vld, b_sro_rdy;
    logic [95:0] b_sci_dat;
    logic [23:0] b_swi_dat;
    logic [7:0]  b_sro_dat, b_swo_dat, b_sri_dat;
    logic        b_sco_vld, b_sco_rdy, b_swo_vld, b_swo_rdy;
    logic        b_sri_vld, b_sri_rdy, b_gnt_vld, b_err;
    logic [31:0] b_sco_dat;
    logic [1:0]  b_gnt_idx;

    sockit_spi_arb #(.CN(2), .CW(32), .DW(8), .PRI(0), .OCW(4)) dut_a (
        .clk(clk), .rst(a_rst),
        .sci_vld(a_sci_vld), .sci_dat(a_sci_dat), .sci_rdy(a_sci_rdy),
        .swi_vld(a_swi_vld), .swi_dat(a_swi_dat), .swi_rdy(a_swi_rdy),
        .sro_vld(a_sro_vld), .sro_dat(a_sro_dat), .sro_rdy(a_sro_rdy),
        .sco_vld(a_sco_vld), .sco_dat(a_sco_dat), .sco_rdy(a_sco_rdy),
        .swo_vld(a_swo_vld), .swo_dat(a_swo_dat), .swo_rdy(a_swo_rdy),
        .sri_vld(a_sri_vld), .sri_dat(a_sri_dat), .sri_rdy(a_sri_rdy),
        .gnt_vld(a_gnt_vld), .gnt_idx(a_gnt_idx), .err_sro(a_err)
    );

    sockit_spi_arb #(.CN(3), .CW(32), .DW(8), .PRI(1), .OCW(2)) dut_b (
        .clk(clk), .rst(b_rst),
        .sci_vld(b_sci_vld), .sci_dat(b_sci_dat), .sci_rdy(b_sci_rdy),
        .swi_vld(b_swi_vld), .swi_dat(b_swi_dat), .swi_rdy(b_swi_rdy),
        .sro_vld(b_sro_vld), .sro_dat(b_sro_dat), .sro_rdy(b_sro_rdy),
        .sco_vld(b_sco_vld), .sco_dat(b_sco_dat), .sco_rdy(b_sco_rdy),
        .swo_vld(b_swo_vld), .swo_dat(b_swo_dat), .swo_rdy(b_swo_rdy),
        .sri_vld(b_sri_vld), .sri_dat(b_sri_dat), .sri_rdy(b_sri_rdy),
        .gnt_vld(b_gnt_vld), .gnt_idx(b_gnt_idx), .err_sro(b_err)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic [39:0] qa_cmd[$], qb_cmd[$];
    logic [15:0] qa_rd[$], qb_rd[$], qa_wr[$], qb_wr[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic bad(string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s", nm);
    endtask

    task automatic drive(bit b, int ch, logic [31:0] c);
        if (b) begin b_sci_dat[ch*32 +: 32] = c; b_sci_vld[ch] = 1'b1; end
        else begin a_sci_dat[ch*32 +: 32] = c; a_sci_vld[ch] = 1'b1; end
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (b ? b_sci_rdy[ch] : a_sci_rdy[ch]) break;
            if (t >= 200) begin bad("cmd_timeout"); break; end
        end
        @(posedge clk); #1;
        if (b) b_sci_vld[ch] = 1'b0; else a_sci_vld[ch] = 1'b0;
    endtask

    task automatic wdrive(bit b, int ch, logic [7:0] d);
        if (b) begin b_swi_dat[ch*8 +: 8] = d; b_swi_vld[ch] = 1'b1; end
        else begin a_swi_dat[ch*8 +: 8] = d; a_swi_vld[ch] = 1'b1; end
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (b ? b_swi_rdy[ch] : a_swi_rdy[ch]) break;
            if (t >= 200) begin bad("wr_timeout"); break; end
        end
        @(posedge clk); #1;
        if (b) b_swi_vld[ch] = 1'b0; else a_swi_vld[ch] = 1'b0;
    endtask

    task automatic rbeat(bit b, logic [7:0] d);
        if (b) begin b_sri_dat = d; b_sri_vld = 1'b1; end
        else begin a_sri_dat = d; a_sri_vld = 1'b1; end
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (b ? b_sri_rdy : a_sri_rdy) break;
            if (t >= 200) begin bad("rd_timeout"); break; end
        end
        @(posedge clk); #1;
        if (b) b_sri_vld = 1'b0; else a_sri_vld = 1'b0;
    endtask

    // Monitor: every serializer-side or requester-side transfer pops
    // the next expected entry.
    always @(negedge clk) begin
        if (!a_rst) begin
            if (a_sco_vld && a_sco_rdy) begin
                if (qa_cmd.size() == 0) bad("a_sco_unexpected");
                else chk("a_sco", {8'(a_gnt_idx), a_sco_dat}, qa_cmd.pop_front());
            end
            if (a_swo_vld && a_swo_rdy) begin
                if (qa_wr.size() == 0) bad("a_swo_unexpected");
                else chk("a_swo", {8'(a_gnt_idx), a_swo_dat}, qa_wr.pop_front());
            end
            for (int i = 0; i < 2; i++)
                if (a_sro_vld[i] && a_sro_rdy[i]) begin
                    if (qa_rd.size() == 0) bad("a_sro_unexpected");
                    else chk("a_sro", {8'(i), a_sro_dat}, qa_rd.pop_front());
                end
        end
        if (!b_rst) begin
            if (b_sco_vld && b_sco_rdy) begin
                if (qb_cmd.size() == 0) bad("b_sco_unexpected");
                else chk("b_sco", {8'(b_gnt_idx), b_sco_dat}, qb_cmd.pop_front());
            end
            if (b_swo_vld && b_swo_rdy) begin
                if (qb_wr.size() == 0) bad("b_swo_unexpected");
                else chk("b_swo", {8'(b_gnt_idx), b_swo_dat}, qb_wr.pop_front());
            end
            for (int i = 0; i < 3; i++)
                if (b_sro_vld[i] && b_sro_rdy[i]) begin
                    if (qb_rd.size() == 0) bad("b_sro_unexpected");
                    else chk("b_sro", {8'(i), b_sro_dat}, qb_rd.pop_front());
                end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst = 1'b1; b_rst = 1'b1;
        a_sci_vld = '0; a_sci_dat = '0; a_swi_vld = '0; a_swi_dat = '0;
        a_sro_rdy = '1; a_sco_rdy = 1'b1; a_swo_rdy = 1'b1;
        a_sri_vld = 1'b0; a_sri_dat = '0;
        b_sci_vld = '0; b_sci_dat = '0; b_swi_vld = '0; b_swi_dat = '0;
        b_sro_rdy = '1; b_sco_rdy = 1'b1; b_swo_rdy = 1'b1;
        b_sri_vld = 1'b0; b_sri_dat = '0;
        repeat (2) @(posedge clk);
        #1; a_rst = 1'b0; b_rst = 1'b0;

        @(negedge clk);
        chk("a_rst_gnt_vld", a_gnt_vld, 0);
        chk("a_rst_gnt_idx", a_gnt_idx, 0);
        chk("a_rst_err", a_err, 0);
        chk("a_rst_sci_rdy", a_sci_rdy, 0);
        chk("a_rst_ptr", dut_a.ptr_q, 1);
        chk("b_rst_gnt_vld", b_gnt_vld, 0);
        chk("b_rst_ptr", dut_b.ptr_q, 2);

        // A: round-robin alternation
        qa_cmd.push_back({8'd0, L | 32'h10});
        qa_cmd.push_back({8'd1, L | 32'h20});
        qa_cmd.push_back({8'd0, L | 32'h11});
        qa_cmd.push_back({8'd1, L | 32'h21});
        @(posedge clk); #1;
        fork
            drive(0, 0, L | 32'h10);
            drive(0, 1, L | 32'h20);
            begin
                @(posedge clk); @(negedge clk);
                chk("a_first_gnt_vld", a_gnt_vld, 1);
                chk("a_first_gnt_idx", a_gnt_idx, 0);
                chk("a_first_sci_rdy", a_sci_rdy, 2'b01);
            end
        join
        @(posedge clk); #1;
        fork
            drive(0, 0, L | 32'h11);
            drive(0, 1, L | 32'h21);
            begin
                @(posedge clk); @(negedge clk);
                chk("a_rr_alt_idx", a_gnt_idx, 0);
            end
        join
        repeat (2) @(posedge clk); #1;

        // A: three reads + lst, delayed read data, drain
        qa_wr.push_back({8'd0, 8'h3C});
        qa_cmd.push_back({8'd0, RD | 32'h1});
        qa_cmd.push_back({8'd0, RD | 32'h2});
        qa_cmd.push_back({8'd0, RD | 32'h3});
        qa_cmd.push_back({8'd0, L | 32'h4});
        qa_rd.push_back({8'd0, 8'hA1});
        qa_rd.push_back({8'd0, 8'hA2});
        qa_rd.push_back({8'd0, 8'hA3});
        fork
            wdrive(0, 0, 8'h3C);
            begin
                drive(0, 0, RD | 32'h1);
                drive(0, 0, RD | 32'h2);
                drive(0, 0, RD | 32'h3);
                drive(0, 0, L | 32'h4);
            end
        join
        @(negedge clk);
        chk("a_drain_state", dut_a.state_q, 64'(ARB_DRAIN));
        chk("a_drain_cnt", dut_a.cnt_q, 3);
        chk("a_drain_sci_rdy", a_sci_rdy, 0);
        repeat (10) @(posedge clk); #1;
        rbeat(0, 8'hA1);
        rbeat(0, 8'hA2);
        rbeat(0, 8'hA3);
        @(negedge clk);
        chk("a_drain_hold", a_gnt_vld, 1);
        @(negedge clk);
        chk("a_drain_idle", a_gnt_vld, 0);

        // A: unsolicited read beat while idle
        @(posedge clk); #1;
        a_sri_dat = 8'h55; a_sri_vld = 1'b1;
        @(negedge clk);
        chk("a_err_sri_rdy", a_sri_rdy, 1);
        chk("a_err_sro_vld", a_sro_vld, 0);
        chk("a_err_pre", a_err, 0);
        @(posedge clk); #1;
        a_sri_vld = 1'b0;
        @(negedge clk);
        chk("a_err_pulse", a_err, 1);
        @(negedge clk);
        chk("a_err_clear", a_err, 0);

        // A: async reset mid-transaction with cnt=2
        qa_cmd.push_back({8'd0, RD | 32'h5});
        qa_cmd.push_back({8'd0, RD | 32'h6});
        @(posedge clk); #1;
        drive(0, 0, RD | 32'h5);
        drive(0, 0, RD | 32'h6);
        @(negedge clk);
        chk("a_pre_rst_cnt", dut_a.cnt_q, 2);
        #2 a_rst = 1'b1;
        #1;
        chk("a_arst_gnt_vld", a_gnt_vld, 0);
        chk("a_arst_cnt", dut_a.cnt_q, 0);
        chk("a_arst_sci_rdy", a_sci_rdy, 0);
        chk("a_arst_swi_rdy", a_swi_rdy, 0);
        @(posedge clk); #1;
        a_rst = 1'b0;
        qa_cmd.push_back({8'd0, L | 32'h7});
        qa_cmd.push_back({8'd1, L | 32'h8});
        @(posedge clk); #1;
        fork
            drive(0, 0, L | 32'h7);
            drive(0, 1, L | 32'h8);
            begin
                @(posedge clk); @(negedge clk);
                chk("a_post_rst_idx", a_gnt_idx, 0);
            end
        join

        // B: fixed priority, grant locked to ch1 until its lst
        qb_cmd.push_back({8'd1, 32'h31});
        qb_cmd.push_back({8'd1, L | 32'h32});
        qb_cmd.push_back({8'd0, L | 32'h30});
        qb_cmd.push_back({8'd2, L | 32'h33});
        @(posedge clk); #1;
        drive(1, 1, 32'h31);
        fork
            drive(1, 0, L | 32'h30);
            drive(1, 2, L | 32'h33);
            begin
                repeat (3) @(negedge clk);
                chk("b_lock_sci_rdy", b_sci_rdy, 3'b010);
                chk("b_lock_gnt_idx", b_gnt_idx, 1);
                @(posedge clk); #1;
                drive(1, 1, L | 32'h32);
            end
        join
        repeat (2) @(posedge clk); #1;

        // B: fourth read stalls at cnt==3
        qb_cmd.push_back({8'd0, RD | 32'h41});
        qb_cmd.push_back({8'd0, RD | 32'h42});
        qb_cmd.push_back({8'd0, RD | 32'h43});
        qb_cmd.push_back({8'd0, RD | 32'h44});
        qb_cmd.push_back({8'd0, L | 32'h45});
        qb_rd.push_back({8'd0, 8'h77});
        qb_rd.push_back({8'd0, 8'h81});
        qb_rd.push_back({8'd0, 8'h82});
        qb_rd.push_back({8'd0, 8'h83});
        drive(1, 0, RD | 32'h41);
        drive(1, 0, RD | 32'h42);
        drive(1, 0, RD | 32'h43);
        fork
            drive(1, 0, RD | 32'h44);
            begin
                repeat (3) @(negedge clk);
                chk("b_stall_sci_rdy", b_sci_rdy[0], 0);
                chk("b_stall_sco_vld", b_sco_vld, 0);
                chk("b_stall_cnt", dut_b.cnt_q, 3);
                @(posedge clk); #1;
                rbeat(1, 8'h77);
            end
        join
        drive(1, 0, L | 32'h45);
        rbeat(1, 8'h81);
        rbeat(1, 8'h82);
        rbeat(1, 8'h83);
        repeat (3) @(negedge clk);
        chk("b_end_gnt_vld", b_gnt_vld, 0);

        chk("qa_cmd_empty", qa_cmd.size(), 0);
        chk("qa_rd_empty", qa_rd.size(), 0);
        chk("qa_wr_empty", qa_wr.size(), 0);
        chk("qb_cmd_empty", qb_cmd.size(), 0);
        chk("qb_rd_empty", qb_rd.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
